// File: rtl/biu_prefetch_queue.sv
// Instruction prefetch queue: circular byte buffer fed by bus code fetches
// and drained one byte at a time by the EU decoder.
module biu_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          BUS_BYTES = 1,
  parameter logic [15:0] RESET_IP  = 16'h0000
) (
  input  logic                         CORE_CLK_INT,
  input  logic                         RESET_INT,
  input  logic                         PFQ_FLUSH,
  input  logic [15:0]                  PFQ_FLUSH_ADDR,
  input  logic                         PFQ_POP,
  output logic [7:0]                   PFQ_TOP_BYTE,
  output logic                         PFQ_EMPTY,
  output logic [15:0]                  PFQ_ADDR_OUT,
  output logic [$clog2(DEPTH+1)-1:0]   PFQ_COUNT,
  output logic                         FETCH_REQ,
  output logic [15:0]                  FETCH_ADDR,
  output logic                         FETCH_WORD,
  input  logic                         FETCH_ACK,
  input  logic [8*BUS_BYTES-1:0]       FETCH_DATA
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_q, state_d;
  logic            word_q, word_d;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     fetch_addr;

  logic [CW-1:0]   free, n_wr;
  logic            odd_lane, want_word, can_req, ack_ok, pop_ok;
  logic [7:0]      byte0, byte1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    free      = CW'(DEPTH) - count;
    odd_lane  = (BUS_BYTES == 2) && fetch_addr[0];
    want_word = (BUS_BYTES == 2) && !fetch_addr[0];
    // A word fetch with one free byte would overflow, so it waits for space
    can_req   = want_word ? (free >= CW'(2)) : (free != '0);
    ack_ok    = FETCH_ACK && (state_q == REQ) && !PFQ_FLUSH;
    pop_ok    = PFQ_POP && (count != '0) && !PFQ_FLUSH;
    byte1     = FETCH_DATA[8*BUS_BYTES-1 -: 8];
    byte0     = odd_lane ? byte1 : FETCH_DATA[7:0];
    n_wr      = ack_ok ? (word_q ? CW'(2) : CW'(1)) : '0;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (!PFQ_FLUSH && can_req) begin
          state_d = REQ;
          word_d  = want_word;
        end
      end
      REQ: begin
        if (FETCH_ACK || PFQ_FLUSH) begin
          state_d = IDLE;
          word_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        word_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CORE_CLK_INT) begin
    if (RESET_INT) begin
      state_q    <= IDLE;
      word_q     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= RESET_IP;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      if (PFQ_FLUSH) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        fetch_addr <= PFQ_FLUSH_ADDR;
      end else begin
        if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
        if (ack_ok) begin
          wr_ptr     <= word_q ? ptr_inc(ptr_inc(wr_ptr)) : ptr_inc(wr_ptr);
          fetch_addr <= fetch_addr + (word_q ? 16'd2 : 16'd1);
        end
        count <= count + n_wr - CW'(pop_ok);
      end
    end
  end

  always_ff @(posedge CORE_CLK_INT) begin
    if (!RESET_INT && ack_ok) begin
      mem[wr_ptr] <= byte0;
      if (word_q) mem[ptr_inc(wr_ptr)] <= byte1;
    end
  end

  assign FETCH_REQ    = (state_q == REQ);
  assign FETCH_ADDR   = fetch_addr;
  assign FETCH_WORD   = word_q;
  assign PFQ_COUNT    = count;
  assign PFQ_EMPTY    = (count == '0);
  assign PFQ_TOP_BYTE = PFQ_EMPTY ? 8'h00 : mem[rd_ptr];
  assign PFQ_ADDR_OUT = fetch_addr - 16'(count);

endmodule

// File: tb/tb_biu_prefetch_queue.sv
// Bench for biu_prefetch_queue: an 8088-style (4 bytes, byte bus) and an
// 8086-style (6 bytes, word bus) instance checked against a queue model.
module tb_biu_prefetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        a_flush, a_pop, a_ack, a_empty, a_req, a_word;
  logic [15:0] a_faddr, a_addr, a_fa;
  logic [7:0]  a_data, a_top;
  logic [2:0]  a_count;

  logic        b_flush, b_pop, b_ack, b_empty, b_req, b_word;
  logic [15:0] b_faddr, b_addr, b_fa, b_data;
  logic [7:0]  b_top;
  logic [2:0]  b_count;

  biu_prefetch_queue #(.DEPTH(4), .BUS_BYTES(1), .RESET_IP(16'h0000)) u_a (
    .CORE_CLK_INT(clk), .RESET_INT(rst), .PFQ_FLUSH(a_flush), .PFQ_FLUSH_ADDR(a_faddr),
    .PFQ_POP(a_pop), .PFQ_TOP_BYTE(a_top), .PFQ_EMPTY(a_empty), .PFQ_ADDR_OUT(a_addr),
    .PFQ_COUNT(a_count), .FETCH_REQ(a_req), .FETCH_ADDR(a_fa), .FETCH_WORD(a_word),
    .FETCH_ACK(a_ack), .FETCH_DATA(a_data));

  biu_prefetch_queue #(.DEPTH(6), .BUS_BYTES(2), .RESET_IP(16'h0000)) u_b (
    .CORE_CLK_INT(clk), .RESET_INT(rst), .PFQ_FLUSH(b_flush), .PFQ_FLUSH_ADDR(b_faddr),
    .PFQ_POP(b_pop), .PFQ_TOP_BYTE(b_top), .PFQ_EMPTY(b_empty), .PFQ_ADDR_OUT(b_addr),
    .PFQ_COUNT(b_count), .FETCH_REQ(b_req), .FETCH_ADDR(b_fa), .FETCH_WORD(b_word),
    .FETCH_ACK(b_ack), .FETCH_DATA(b_data));

  logic [7:0]  d_top[2];
  logic [15:0] d_addr[2], d_fa[2];
  logic [2:0]  d_count[2];
  logic        d_empty[2], d_req[2], d_word[2];
  assign d_top[0] = a_top;     assign d_top[1] = b_top;
  assign d_addr[0] = a_addr;   assign d_addr[1] = b_addr;
  assign d_fa[0] = a_fa;       assign d_fa[1] = b_fa;
  assign d_count[0] = a_count; assign d_count[1] = b_count;
  assign d_empty[0] = a_empty; assign d_empty[1] = b_empty;
  assign d_req[0] = a_req;     assign d_req[1] = b_req;
  assign d_word[0] = a_word;   assign d_word[1] = b_word;

  // Reference: byte queue, next fetch offset, and the outstanding request
  logic [7:0]  mq[2][$];
  logic [15:0] mfa[2];
  bit          mreq[2], mword[2];
  int          m_depth[2] = '{4, 6};
  int          m_bus[2]   = '{1, 2};

  task automatic model_step(input int i, input bit fl, input logic [15:0] fad,
                            input bit pp, input bit ak, input logic [15:0] dat);
    int sz;
    int free;
    sz = mq[i].size();
    if (fl) begin
      mq[i].delete();
      mfa[i]  = fad;
      mreq[i] = 0;
      return;
    end
    if (pp && sz > 0) void'(mq[i].pop_front());
    if (mreq[i]) begin
      if (ak) begin
        if (mword[i]) begin
          mq[i].push_back(dat[7:0]);
          mq[i].push_back(dat[15:8]);
          mfa[i] = mfa[i] + 16'd2;
        end else begin
          mq[i].push_back((m_bus[i] == 2 && mfa[i][0]) ? dat[15:8] : dat[7:0]);
          mfa[i] = mfa[i] + 16'd1;
        end
        mreq[i] = 0;
      end
    end else begin
      free = m_depth[i] - sz;
      if (m_bus[i] == 2 && !mfa[i][0]) begin
        if (free >= 2) begin mreq[i] = 1; mword[i] = 1; end
      end else if (free >= 1) begin
        mreq[i] = 1; mword[i] = 0;
      end
    end
  endtask

  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete(); mfa[i] = 16'h0000; mreq[i] = 0; mword[i] = 0;
      end
    end else begin
      model_step(0, a_flush, a_faddr, a_pop, a_ack, {8'h00, a_data});
      model_step(1, b_flush, b_faddr, b_pop, b_ack, b_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", a_empty); end
    n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", a_count); end
    n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", a_req); end
    n_checks++; if (a_top !== 8'h00) begin n_fail++; $display("FAIL reset_top got %h exp 00", a_top); end
    n_checks++; if (b_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr_out got %h exp 0000", b_addr); end
    rst = 1'b0;
    tick();
    n_checks++; if (a_req !== 1'b1 || a_fa !== 16'h0000 || a_word !== 1'b0) begin n_fail++; $display("FAIL reset_first_req got req=%b addr=%h word=%b exp 1/0000/0", a_req, a_fa, a_word); end
    n_checks++; if (b_req !== 1'b1 || b_fa !== 16'h0000 || b_word !== 1'b1) begin n_fail++; $display("FAIL reset_first_word_req got req=%b addr=%h word=%b exp 1/0000/1", b_req, b_fa, b_word); end
  endtask

  task automatic test_fill_pop();
    logic [7:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      a_ack = 1'b1; a_data = vals[k];
      tick();
      a_ack = 1'b0;
      tick();
    end
    n_checks++; if (a_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", a_count); end
    n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL fill_full_req got %b exp 0", a_req); end
    a_ack = 1'b1; a_data = 8'h99;
    tick();
    a_ack = 1'b0;
    n_checks++; if (a_count !== 3'd4 || a_top !== 8'h11 || a_addr !== 16'h0000) begin n_fail++; $display("FAIL fill_idle_ack got count=%0d top=%h addr=%h exp 4/11/0000", a_count, a_top, a_addr); end
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    n_checks++; if (a_top !== 8'h22 || a_addr !== 16'h0001 || a_count !== 3'd3) begin n_fail++; $display("FAIL pop_top got top=%h addr=%h count=%0d exp 22/0001/3", a_top, a_addr, a_count); end
    tick();
    n_checks++; if (a_req !== 1'b1 || a_fa !== 16'h0004) begin n_fail++; $display("FAIL pop_refetch got req=%b addr=%h exp 1/0004", a_req, a_fa); end
  endtask

  task automatic test_odd_flush();
    b_flush = 1'b1; b_faddr = 16'h0103;
    tick();
    b_flush = 1'b0;
    n_checks++; if (b_req !== 1'b0 || b_count !== 3'd0) begin n_fail++; $display("FAIL odd_flush_clear got req=%b count=%0d exp 0/0", b_req, b_count); end
    tick();
    n_checks++; if (b_req !== 1'b1 || b_fa !== 16'h0103 || b_word !== 1'b0) begin n_fail++; $display("FAIL odd_byte_req got req=%b addr=%h word=%b exp 1/0103/0", b_req, b_fa, b_word); end
    b_ack = 1'b1; b_data = 16'hABCD;
    tick();
    b_ack = 1'b0;
    n_checks++; if (b_top !== 8'hAB || b_addr !== 16'h0103 || b_count !== 3'd1) begin n_fail++; $display("FAIL odd_lane_data got top=%h addr=%h count=%0d exp AB/0103/1", b_top, b_addr, b_count); end
    tick();
    n_checks++; if (b_req !== 1'b1 || b_fa !== 16'h0104 || b_word !== 1'b1) begin n_fail++; $display("FAIL odd_then_word got req=%b addr=%h word=%b exp 1/0104/1", b_req, b_fa, b_word); end
  endtask

  task automatic test_word_stall();
    b_ack = 1'b1; b_data = 16'h2211; tick();
    b_ack = 1'b0; tick();
    b_ack = 1'b1; b_data = 16'h4433; tick();
    b_ack = 1'b0; tick();
    n_checks++; if (b_req !== 1'b0 || b_count !== 3'd5) begin n_fail++; $display("FAIL stall_no_req got req=%b count=%0d exp 0/5", b_req, b_count); end
    b_pop = 1'b1; tick();
    b_pop = 1'b0;
    n_checks++; if (b_req !== 1'b0 || b_count !== 3'd4) begin n_fail++; $display("FAIL stall_after_pop got req=%b count=%0d exp 0/4", b_req, b_count); end
    tick();
    n_checks++; if (b_req !== 1'b1 || b_word !== 1'b1 || b_fa !== 16'h0108) begin n_fail++; $display("FAIL stall_word_req got req=%b word=%b addr=%h exp 1/1/0108", b_req, b_word, b_fa); end
    b_pop = 1'b1; b_ack = 1'b1; b_data = 16'h6655; tick();
    b_pop = 1'b0; b_ack = 1'b0;
    n_checks++; if (b_count !== 3'd5 || b_top !== 8'h22 || b_addr !== 16'h0105) begin n_fail++; $display("FAIL pop_ack_same got count=%0d top=%h addr=%h exp 5/22/0105", b_count, b_top, b_addr); end
  endtask

  task automatic test_flush_during_fetch();
    a_flush = 1'b1; a_ack = 1'b1; a_pop = 1'b1; a_data = 8'h77; a_faddr = 16'h2000;
    tick();
    a_flush = 1'b0; a_ack = 1'b0;
    n_checks++; if (a_count !== 3'd0 || a_req !== 1'b0 || a_addr !== 16'h2000 || a_top !== 8'h00) begin n_fail++; $display("FAIL flush_drop got count=%0d req=%b addr=%h top=%h exp 0/0/2000/00", a_count, a_req, a_addr, a_top); end
    tick();
    a_pop = 1'b0;
    n_checks++; if (a_req !== 1'b1 || a_fa !== 16'h2000 || a_count !== 3'd0) begin n_fail++; $display("FAIL flush_refetch got req=%b addr=%h count=%0d exp 1/2000/0", a_req, a_fa, a_count); end
  endtask

  task automatic test_wrap();
    b_flush = 1'b1; b_faddr = 16'hFFFF; tick();
    b_flush = 1'b0; tick();
    n_checks++; if (b_req !== 1'b1 || b_fa !== 16'hFFFF || b_word !== 1'b0) begin n_fail++; $display("FAIL wrap_byte_req got req=%b addr=%h word=%b exp 1/FFFF/0", b_req, b_fa, b_word); end
    b_ack = 1'b1; b_data = 16'h5A00; tick();
    b_ack = 1'b0;
    n_checks++; if (b_top !== 8'h5A || b_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_byte_data got top=%h addr=%h exp 5A/FFFF", b_top, b_addr); end
    tick();
    n_checks++; if (b_req !== 1'b1 || b_fa !== 16'h0000 || b_word !== 1'b1) begin n_fail++; $display("FAIL wrap_word_req got req=%b addr=%h word=%b exp 1/0000/1", b_req, b_fa, b_word); end
    b_ack = 1'b1; b_data = 16'h2211; tick();
    b_ack = 1'b0;
    n_checks++; if (b_count !== 3'd3 || b_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_fill got count=%0d addr=%h exp 3/FFFF", b_count, b_addr); end
    b_pop = 1'b1; tick();
    n_checks++; if (b_addr !== 16'h0000 || b_top !== 8'h11) begin n_fail++; $display("FAIL wrap_pop1 got addr=%h top=%h exp 0000/11", b_addr, b_top); end
    tick();
    b_pop = 1'b0;
    n_checks++; if (b_addr !== 16'h0001 || b_top !== 8'h22) begin n_fail++; $display("FAIL wrap_pop2 got addr=%h top=%h exp 0001/22", b_addr, b_top); end
  endtask

  task automatic test_random();
    logic [7:0] exp_top;
    for (int k = 0; k < 800; k++) begin
      a_flush = ($urandom_range(0, 24) == 0);
      b_flush = ($urandom_range(0, 24) == 0);
      a_faddr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b_faddr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      a_pop   = ($urandom_range(0, 1) == 1);
      b_pop   = ($urandom_range(0, 2) == 0);
      a_ack   = ($urandom_range(0, 9) < 5);
      b_ack   = ($urandom_range(0, 9) < 6);
      a_data  = 8'($urandom);
      b_data  = 16'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        exp_top = (mq[i].size() > 0) ? mq[i][0] : 8'h00;
        n_checks++; if (d_count[i] !== 3'(mq[i].size())) begin n_fail++; $display("FAIL rnd_count[%0d] cyc %0d got %0d exp %0d", i, k, d_count[i], mq[i].size()); end
        n_checks++; if (d_empty[i] !== (mq[i].size() == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d] cyc %0d got %b exp %b", i, k, d_empty[i], mq[i].size() == 0); end
        n_checks++; if (d_top[i] !== exp_top) begin n_fail++; $display("FAIL rnd_top[%0d] cyc %0d got %h exp %h", i, k, d_top[i], exp_top); end
        n_checks++; if (d_addr[i] !== 16'(mfa[i] - 16'(mq[i].size()))) begin n_fail++; $display("FAIL rnd_addr_out[%0d] cyc %0d got %h exp %h", i, k, d_addr[i], 16'(mfa[i] - 16'(mq[i].size()))); end
        n_checks++; if (d_req[i] !== mreq[i]) begin n_fail++; $display("FAIL rnd_req[%0d] cyc %0d got %b exp %b", i, k, d_req[i], mreq[i]); end
        n_checks++; if (d_fa[i] !== mfa[i]) begin n_fail++; $display("FAIL rnd_fetch_addr[%0d] cyc %0d got %h exp %h", i, k, d_fa[i], mfa[i]); end
        if (mreq[i]) begin
          n_checks++; if (d_word[i] !== mword[i]) begin n_fail++; $display("FAIL rnd_word[%0d] cyc %0d got %b exp %b", i, k, d_word[i], mword[i]); end
        end
      end
    end
    a_flush = 1'b0; b_flush = 1'b0; a_pop = 1'b0; b_pop = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_faddr = '0; a_pop = 1'b0; a_ack = 1'b0; a_data = '0;
    b_flush = 1'b0; b_faddr = '0; b_pop = 1'b0; b_ack = 1'b0; b_data = '0;
    test_reset();
    test_fill_pop();
    test_odd_flush();
    test_word_stall();
    test_flush_during_fetch();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
